// File: rtl/sr_shift_ctrl_if.sv
// Wishbone classic slave bus between the management core and sr_shift_ctrl.
// The master drives the strobes, address and write data; the slave returns a one-cycle ack and read data.
interface sr_shift_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/sr_shift_ctrl.sv
// Wishbone-mapped serial shift-chain sequencer: shifts TXDATA out MSB-first, captures the returning bits, pulses latch.
// Bus ack one cycle after request, every other cycle back-to-back; register writes are dropped (still acked) while busy.
module sr_shift_ctrl #(
  parameter int          DIV_W    = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  sr_shift_ctrl_if.slave wb,
  output logic           sr_clk_o,
  output logic           sr_dat_o,
  output logic           sr_lat_o,
  input  logic           sr_dat_i,
  output logic           irq_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_LATCH} state_t;

  state_t           state, state_nxt;
  logic             irq_en, done;
  logic [4:0]       len, bit_cnt, len_start;
  logic [DIV_W-1:0] div, div_lat, ph_cnt;
  logic [31:0]      txdata, rxdata, tx_sh, rx_sh;
  logic [31:0]      rd_mux, tx_merged, div_merged;
  logic             hit, req, wr, busy, start, w1c, ph_zero;
  logic             load, capture, shift, reload, finish;
  logic [2:0]       reg_sel;
  logic             unused_adr;

  assign hit        = wb.wbs_adr_i[31:8] == BASE_ADR[31:8];
  assign req        = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o & hit;
  assign wr         = req & wb.wbs_we_i;
  assign reg_sel    = wb.wbs_adr_i[4:2];
  assign unused_adr = ^{wb.wbs_adr_i[7:5], wb.wbs_adr_i[1:0]};
  assign busy       = state != ST_IDLE;
  assign start      = wr & (reg_sel == 3'd0) & wb.wbs_sel_i[0] & wb.wbs_dat_i[0] & ~busy;
  assign w1c        = wr & (reg_sel == 3'd4) & wb.wbs_sel_i[0] & wb.wbs_dat_i[1];
  // LEN written together with START takes effect for that very transfer
  assign len_start  = wb.wbs_sel_i[1] ? wb.wbs_dat_i[12:8] : len;
  assign ph_zero    = ph_cnt == '0;

  always_comb begin
    tx_merged  = txdata;
    div_merged = 32'(div);
    for (int b = 0; b < 4; b++) begin
      if (wb.wbs_sel_i[b]) begin
        tx_merged[8*b +: 8]  = wb.wbs_dat_i[8*b +: 8];
        div_merged[8*b +: 8] = wb.wbs_dat_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      3'd0:    rd_mux = {19'b0, len, 6'b0, irq_en, 1'b0};
      3'd1:    rd_mux = 32'(div);
      3'd2:    rd_mux = txdata;
      3'd3:    rd_mux = rxdata;
      3'd4:    rd_mux = {30'b0, done, busy};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    shift     = 1'b0;
    reload    = 1'b0;
    finish    = 1'b0;
    sr_clk_o  = 1'b0;
    sr_dat_o  = 1'b0;
    sr_lat_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_LOW;
        end
      end
      ST_LOW: begin
        sr_dat_o = tx_sh[31];
        if (ph_zero) begin
          capture   = 1'b1;
          reload    = 1'b1;
          state_nxt = ST_HIGH;
        end
      end
      ST_HIGH: begin
        sr_clk_o = 1'b1;
        sr_dat_o = tx_sh[31];
        if (ph_zero) begin
          reload = 1'b1;
          if (bit_cnt == 5'd0) begin
            state_nxt = ST_LATCH;
          end else begin
            shift     = 1'b1;
            state_nxt = ST_LOW;
          end
        end
      end
      ST_LATCH: begin
        sr_lat_o = 1'b1;
        if (ph_zero) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      irq_en       <= 1'b0;
      len          <= '0;
      div          <= '0;
      div_lat      <= '0;
      txdata       <= '0;
      rxdata       <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      bit_cnt      <= '0;
      ph_cnt       <= '0;
      done         <= 1'b0;
      irq_o        <= 1'b0;
    end else begin
      wb.wbs_ack_o <= req;
      wb.wbs_dat_o <= (req & ~wb.wbs_we_i) ? rd_mux : '0;

      if (wr && !busy) begin
        case (reg_sel)
          3'd0: begin
            if (wb.wbs_sel_i[0]) irq_en <= wb.wbs_dat_i[1];
            if (wb.wbs_sel_i[1]) len    <= wb.wbs_dat_i[12:8];
          end
          3'd1:    div    <= div_merged[DIV_W-1:0];
          3'd2:    txdata <= tx_merged;
          default: ;
        endcase
      end

      if (load) begin
        tx_sh   <= txdata << (5'd31 - len_start);
        rx_sh   <= '0;
        bit_cnt <= len_start;
        ph_cnt  <= div;
        div_lat <= div;
      end else begin
        if (reload)             ph_cnt <= div_lat;
        else if (busy)          ph_cnt <= ph_cnt - 1'b1;
        if (capture)            rx_sh  <= {rx_sh[30:0], sr_dat_i};
        if (shift) begin
          tx_sh   <= tx_sh << 1;
          bit_cnt <= bit_cnt - 5'd1;
        end
      end

      if (finish) rxdata <= rx_sh;

      // a completion landing on the same edge as a clear must stay visible
      if (finish)   done <= 1'b1;
      else if (w1c) done <= 1'b0;

      irq_o <= done & irq_en;
    end
  end

endmodule

// File: tb/tb_sr_shift_ctrl.sv
// Bench for sr_shift_ctrl: directed and randomized transfers checked against an arithmetic reference model.
// Observes chain pins and bus reads only; one summary line at the end.
module tb_sr_shift_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_DIV  = BASE + 32'h04;
  localparam logic [31:0] A_TX   = BASE + 32'h08;
  localparam logic [31:0] A_RX   = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;
  localparam logic [31:0] A_UNM  = BASE + 32'h14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sr_clk, sr_dat, sr_lat, sr_in, irq;
  logic invert = 1'b0;

  sr_shift_ctrl_if wb();

  assign sr_in = sr_dat ^ invert;

  sr_shift_ctrl #(.DIV_W(16), .BASE_ADR(32'h3000_0000)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (wb),
    .sr_clk_o (sr_clk),
    .sr_dat_o (sr_dat),
    .sr_lat_o (sr_lat),
    .sr_dat_i (sr_in),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  // pin monitor, sampled on the falling edge
  int          cyc_cnt = 0, rises = 0, hi_cyc = 0, lat_cyc = 0, lat_pulses = 0;
  int          last_lat_c = 0, fall_c = -10;
  logic        clk_prev = 1'b0, lat_prev = 1'b0;
  logic        irq_at_fall = 1'b0, irq_after_fall = 1'b0;
  logic [31:0] seq = '0;

  always @(negedge clk) begin
    cyc_cnt++;
    if (sr_clk && !clk_prev) begin
      rises++;
      seq = {seq[30:0], sr_dat};
    end
    if (sr_clk) hi_cyc++;
    if (sr_lat) begin
      lat_cyc++;
      last_lat_c = cyc_cnt;
      if (!lat_prev) lat_pulses++;
    end
    if (lat_prev && !sr_lat) begin
      fall_c      = cyc_cnt;
      irq_at_fall = irq;
    end
    if (cyc_cnt == fall_c + 1) irq_after_fall = irq;
    clk_prev = sr_clk;
    lat_prev = sr_lat;
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int ack_c = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    int n;
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = wdat;
    wb.wbs_sel_i = sel;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb.wbs_ack_o && n < 8);
    ack_c = cyc_cnt + 1;
    rdat  = wb.wbs_dat_o;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    if (!wb.wbs_ack_o) check("wb_ack_timeout", 32'(wb.wbs_ack_o), 32'd1);
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, 4'hF, dummy);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'h0, 4'hF, d);
  endtask

  // reference model: chain behaviour from plain arithmetic
  function automatic logic [31:0] mask_of(input int len);
    logic [31:0] m;
    if (len >= 31) m = 32'hFFFF_FFFF;
    else           m = (32'd1 << (len + 1)) - 32'd1;
    return m;
  endfunction

  function automatic int busy_cycles(input int len, input int div);
    return (len + 1) * 2 * (div + 1) + (div + 1);
  endfunction

  task automatic run_xfer(input logic [31:0] tx, input int len, input int div,
                          input logic inv, input logic ien, input logic meddle);
    logic [31:0] d, ctrl, m, exp_rx;
    int r0, h0, l0, p0, c0, n, lim;
    m      = mask_of(len);
    exp_rx = (inv ? ~tx : tx) & m;
    wb_wr(A_STAT, 32'h2);
    wb_wr(A_DIV, 32'(div));
    wb_wr(A_TX, tx);
    invert = inv;
    r0 = rises; h0 = hi_cyc; l0 = lat_cyc; p0 = lat_pulses;
    ctrl = 32'd1;
    ctrl[1] = ien;
    ctrl[12:8] = 5'(len);
    wb_wr(A_CTRL, ctrl);
    c0 = ack_c;
    wb_rd(A_STAT, d);
    check("status_busy", d, 32'h1);
    if (meddle) begin
      wb_wr(A_TX, 32'h0000_1234);
      wb_wr(A_DIV, 32'd9);
      wb_wr(A_CTRL, 32'h0000_0001);
    end
    lim = busy_cycles(len, div) + 50;
    n = 0;
    while (!(lat_pulses > p0 && !lat_prev) && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= lim) check("xfer_timeout", 32'(n), 32'(lim - 1));
    check("busy_cycles", 32'(last_lat_c - c0 + 1), 32'(busy_cycles(len, div)));
    check("clk_rises",   32'(rises - r0),           32'(len + 1));
    check("clk_high",    32'(hi_cyc - h0),          32'((len + 1) * (div + 1)));
    check("lat_cycles",  32'(lat_cyc - l0),         32'(div + 1));
    check("lat_pulses",  32'(lat_pulses - p0),      32'd1);
    check("dat_seq",     seq & m,                   tx & m);
    wb_rd(A_RX, d);
    check("rxdata", d, exp_rx);
    wb_rd(A_STAT, d);
    check("status_done", d, 32'h2);
    check("irq_at_done",  32'(irq_at_fall),    32'd0);
    check("irq_after",    32'(irq_after_fall), 32'(ien));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, tx;
    int r0, p0, n;

    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;

    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pins", {27'b0, sr_clk, sr_dat, sr_lat, irq, wb.wbs_ack_o}, 32'h0);
    check("rst_dat_o", wb.wbs_dat_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 5; a++) begin
      wb_rd(BASE + 32'(4 * a), d);
      check("rst_reg", d, 32'h0);
    end

    // byte enables and unmapped offset
    wb_xfer(1'b1, A_DIV, 32'hFFFF_FF05, 4'b0001, d);
    wb_rd(A_DIV, d);
    check("div_sel_byte0", d, 32'h5);
    wb_wr(A_UNM, 32'hFFFF_FFFF);
    wb_rd(A_UNM, d);
    check("unmapped_read", d, 32'h0);

    // loopback 0xA5, 8 bits, DIV=0
    run_xfer(32'h0000_00A5, 7, 0, 1'b0, 1'b0, 1'b0);

    // 32 bits, DIV=3, with writes attempted while busy
    run_xfer(32'hDEAD_BEEF, 31, 3, 1'b0, 1'b0, 1'b1);
    wb_rd(A_TX, d);
    check("tx_kept", d, 32'hDEAD_BEEF);
    wb_rd(A_DIV, d);
    check("div_kept", d, 32'h3);
    wb_rd(A_CTRL, d);
    check("ctrl_kept", d, 32'h0000_1F00);

    // interrupt and its clear
    run_xfer($urandom, 3, 1, 1'b0, 1'b1, 1'b0);
    check("irq_high", 32'(irq), 32'd1);
    wb_wr(A_STAT, 32'h2);
    check("irq_clear_edge", 32'(irq), 32'd1);
    @(posedge clk); #1;
    check("irq_cleared", 32'(irq), 32'd0);

    // clear coinciding with completion: LEN=0, DIV=0 finishes 3 edges after START
    wb_wr(A_DIV, 32'd0);
    wb_wr(A_CTRL, 32'h0000_0003);
    repeat (2) @(negedge clk);
    wb_wr(A_STAT, 32'h2);
    repeat (3) @(posedge clk);
    wb_rd(A_STAT, d);
    check("done_set_wins", d, 32'h2);
    wb_wr(A_STAT, 32'h2);
    wb_wr(A_CTRL, 32'h0);

    // reset in the middle of a transfer
    invert = 1'b0;
    wb_wr(A_DIV, 32'd1);
    wb_wr(A_TX, $urandom);
    r0 = rises;
    p0 = lat_pulses;
    wb_wr(A_CTRL, 32'h0000_0701);
    n = 0;
    while (rises - r0 < 4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("mid_reset_wait", 32'(rises - r0), 32'd4);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_pins", {28'b0, sr_clk, sr_dat, sr_lat, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_no_latch", 32'(lat_pulses - p0), 32'd0);
    wb_rd(A_STAT, d);
    check("mid_rst_status", d, 32'h0);
    run_xfer($urandom, 5, 1, 1'b0, 1'b0, 1'b0);

    // randomized transfers
    for (int i = 0; i < 6; i++) begin
      tx = $urandom;
      run_xfer(tx, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sr_shift_ctrl.md
# sr_shift_ctrl

Wishbone-mapped controller that sequences an external serial shift-register chain driven from user-project GPIOs. The management core loads a word, length and clock divider over the Caravel Wishbone bus; the block then generates shift clock, serial data and latch pulse, captures the returning chain data, and raises a sticky done flag with an optional interrupt. It sits in the user project area between the Wishbone slave port and the `mprj_io` pads.

## Interface
- `DIV_W`, 16: width of the half-period divider register.
- `BASE_ADR`, 32'h3000_0000: base address; block decodes `wbs_adr_i[31:8] == BASE_ADR[31:8]`.
- `wb_clk_i`  in  1  single clock for all logic.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1  Wishbone classic strobes.
- `wbs_sel_i`  in  4  byte enables (honoured on all writable registers).
- `wbs_adr_i`  in  32  byte address; `[4:2]` selects register.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data, valid with ack.
- `sr_clk_o`  out  1  shift clock to chain.
- `sr_dat_o`  out  1  serial data to chain.
- `sr_lat_o`  out  1  latch/strobe pulse after last bit.
- `sr_dat_i`  in  1  serial data returning from chain end.
- `irq_o`  out  1  level interrupt, `done & irq_en`.

## Operation
- Registers (offset): 0x00 CTRL: bit0 START (write-1, self-clearing, reads 0), bit1 IRQ_EN, bits[12:8] LEN (bits shifted = LEN+1, 1..32). 0x04 DIV: `[DIV_W-1:0]`, phase length = DIV+1 cycles. 0x08 TXDATA. 0x0C RXDATA (read-only). 0x10 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear). Unmapped offsets read 0, writes dropped, still acked.
- FSM states: IDLE, LOW, HIGH, LATCH.
- IDLE: START=1 write -> load TX shifter with TXDATA aligned so bit LEN goes first (MSB-first), clear RX shifter, bit counter = LEN, phase counter = DIV -> LOW.
- LOW: `sr_clk_o`=0, `sr_dat_o` = current TX MSB; after DIV+1 cycles -> HIGH, capturing `sr_dat_i` into RX shifter LSB (shift left).
- HIGH: `sr_clk_o`=1; after DIV+1 cycles: if counter==0 -> LATCH, else shift TX, decrement counter -> LOW.
- LATCH: `sr_lat_o`=1 for DIV+1 cycles -> IDLE; same edge copies RX shifter to RXDATA (first captured bit ends at bit LEN, last at bit 0, upper bits 0) and sets DONE.
- BUSY = (state != IDLE).
- While BUSY: writes to CTRL, DIV, TXDATA ignored (acked); STATUS W1C still allowed; START ignored.
- DONE set and W1C in same cycle: set wins.
- DIV and LEN sampled only at START; not re-read mid-transfer.

## Timing
- Reset (sync, next edge): state IDLE; `wbs_ack_o`, `sr_clk_o`, `sr_dat_o`, `sr_lat_o`, `irq_o` = 0; `wbs_dat_o` = 0; all registers 0 (LEN=0, DIV=0). Reset mid-transfer aborts immediately, no latch pulse, DONE stays 0.
- Wishbone: request sampled at edge with `cyc&stb&!ack`; ack high for exactly one cycle from that edge; register write and read data take effect on that same edge; back-to-back requests ack every other cycle.
- START accepted at edge E: BUSY=1 and state LOW from E; first `sr_clk_o` rise at E+(DIV+1).
- Total BUSY cycles = (LEN+1)·2·(DIV+1) + (DIV+1); IDLE and DONE=1 at the edge ending LATCH.
- `irq_o` registered, high the cycle after DONE sets while IRQ_EN=1.

## Test plan
- Reset: assert `wb_rst_i` 2 cycles -> all outputs 0, reads of 0x00–0x10 return 0.
- Loopback (`sr_dat_i`=`sr_dat_o`), TXDATA=0xA5, LEN=7, DIV=0, START -> BUSY exactly 17 cycles, 8 clock rises, `sr_dat_o` sequence 1,0,1,0,0,1,0,1, one 1-cycle latch, RXDATA=0x0000_00A5, DONE=1.
- DIV=3, LEN=31, TXDATA=0xDEAD_BEEF -> each clock phase 4 cycles, BUSY 260 cycles, RXDATA=0xDEAD_BEEF.
- Writes while BUSY (TXDATA=0x1234, DIV=9, START) -> ignored, transfer completes with original values, single DONE.
- IRQ_EN=1, transfer completes -> `irq_o`=1; STATUS write 0x2 -> `irq_o`=0 next cycle; W1C coinciding with DONE set -> DONE remains 1.
- Assert reset at mid-transfer bit 4 -> outputs 0 next edge, no `sr_lat_o`, DONE=0, new START works normally.
